// File: rtl/uart_tx_cfg_if.sv
// Producer-side handshake and line signals for uart_tx_cfg.
// The producer uses the master modport and the transmitter uses the slave modport.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_dv;
  logic [DATA_BITS-1:0] tx_byte;
  logic                 tx_ready;
  logic                 tx_active;
  logic                 tx_serial;
  logic                 tx_done;

  modport master (
    output tx_dv, tx_byte,
    input  tx_ready, tx_active, tx_serial, tx_done
  );

  modport slave (
    input  tx_dv, tx_byte,
    output tx_ready, tx_active, tx_serial, tx_done
  );
endinterface

// File: rtl/uart_tx_cfg.sv
// UART transmitter with an elaboration-time frame format and a one-word holding register.
// The holding register lets the next frame follow the current one with no idle gap.
module uart_tx_cfg #(
  parameter int CLKS_PER_BIT = 8700,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  uart_tx_cfg_if.slave tx
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t               state;
  logic [CNT_W-1:0]     clk_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shifter;
  logic [DATA_BITS-1:0] hold;
  logic                 full;
  logic                 serial_q;
  logic                 active_q;
  logic                 done_pre;
  logic                 done_q;
  logic                 bit_end;
  logic                 par_bit;

  assign bit_end = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign par_bit = (PARITY == 1) ? ~(^shifter) : (^shifter);

  assign tx.tx_ready  = !full;
  assign tx.tx_active = active_q;
  assign tx.tx_serial = serial_q;
  assign tx.tx_done   = done_q;

  // Line outputs are registered from the current state, so the line trails the
  // state by one cycle; done_pre adds one more stage so the pulse lands in the
  // cycle after the last stop-bit cycle seen on the line.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shifter  <= '0;
      hold     <= '0;
      full     <= 1'b0;
      serial_q <= 1'b1;
      active_q <= 1'b0;
      done_pre <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_pre <= 1'b0;
      done_q   <= done_pre;
      active_q <= (state != IDLE);

      unique case (state)
        IDLE:    serial_q <= 1'b1;
        START:   serial_q <= 1'b0;
        DATA:    serial_q <= shifter[bit_idx];
        PAR:     serial_q <= par_bit;
        STOP:    serial_q <= 1'b1;
        default: serial_q <= 1'b1;
      endcase

      if (tx.tx_dv && !full) begin
        hold <= tx.tx_byte;
        full <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_idx <= '0;
          if (full) begin
            shifter <= hold;
            full    <= 1'b0;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? PAR : STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        PAR: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              bit_idx  <= '0;
              done_pre <= 1'b1;
              if (full) begin
                shifter <= hold;
                full    <= 1'b0;
                state   <= START;
              end else begin
                state   <= IDLE;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected line symbol strings are queued per
// instance at send time and a per-instance monitor checks every line cycle.
module tb_uart_tx_cfg;
  localparam int N = 5;

  logic clk;
  logic rst_n [N];
  logic dv    [N];
  logic [8:0] byt [N];
  bit   mon_en [N];
  bit   busy   [N];
  bit   sim_end;
  int   checks;
  int   errors;
  string exp_q [N][$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if3 ();
  uart_tx_cfg_if #(.DATA_BITS(5)) if4 ();

  assign if0.tx_dv = dv[0];  assign if0.tx_byte = byt[0][7:0];
  assign if1.tx_dv = dv[1];  assign if1.tx_byte = byt[1][7:0];
  assign if2.tx_dv = dv[2];  assign if2.tx_byte = byt[2][7:0];
  assign if3.tx_dv = dv[3];  assign if3.tx_byte = byt[3][6:0];
  assign if4.tx_dv = dv[4];  assign if4.tx_byte = byt[4][4:0];

  wire [N-1:0] ser = {if4.tx_serial, if3.tx_serial, if2.tx_serial, if1.tx_serial, if0.tx_serial};
  wire [N-1:0] act = {if4.tx_active, if3.tx_active, if2.tx_active, if1.tx_active, if0.tx_active};
  wire [N-1:0] dn  = {if4.tx_done,   if3.tx_done,   if2.tx_done,   if1.tx_done,   if0.tx_done};
  wire [N-1:0] rdy = {if4.tx_ready,  if3.tx_ready,  if2.tx_ready,  if1.tx_ready,  if0.tx_ready};

  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    u0 (.i_clock(clk), .i_reset_n(rst_n[0]), .tx(if0));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
    u1 (.i_clock(clk), .i_reset_n(rst_n[1]), .tx(if1));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1))
    u2 (.i_clock(clk), .i_reset_n(rst_n[2]), .tx(if2));
  uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
    u3 (.i_clock(clk), .i_reset_n(rst_n[3]), .tx(if3));
  uart_tx_cfg #(.CLKS_PER_BIT(8700), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1))
    u4 (.i_clock(clk), .i_reset_n(rst_n[4]), .tx(if4));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic push(input int id, input string syms);
    exp_q[id].push_back(syms);
  endtask

  task automatic send(input int id, input logic [8:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!rdy[id] && n < 100000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("inst%0d_ready_before_send", id), {31'd0, rdy[id]}, 32'd1);
    dv[id]  = 1'b1;
    byt[id] = w;
    @(posedge clk);
    #1;
    dv[id]  = 1'b0;
  endtask

  task automatic wait_idle(input int id);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_q[id].size() != 0 || busy[id] || act[id] || !rdy[id]) && n < 100000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("inst%0d_idle_reached", id), {31'd0, act[id]}, 32'd0);
  endtask

  // Each symbol must hold for exactly cpb cycles; done must be quiet inside the
  // frame and pulse in the cycle right after the final stop cycle.
  task automatic mon(input int id, input int cpb);
    string s;
    int    n;
    logic  e, badv;
    bit    sym_ok, act_ok, dn_ok, skip;
    skip = 1'b0;
    while (!sim_end) begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (mon_en[id] && ser[id] === 1'b0) begin
        checks++;
        if (exp_q[id].size() == 0) begin
          errors++;
          $display("FAIL inst%0d unexpected_frame: line=0 required=1 (nothing pending)", id);
          for (int w = 0; w < 100000 && ser[id] !== 1'b1; w++) @(negedge clk);
        end else begin
          busy[id] = 1'b1;
          s = exp_q[id].pop_front();
          n = s.len();
          act_ok = 1'b1;
          dn_ok  = 1'b1;
          for (int k = 0; k < n; k++) begin
            e = (s[k] == "1");
            sym_ok = 1'b1;
            badv = e;
            for (int c = 0; c < cpb; c++) begin
              if (k > 0 || c > 0) @(negedge clk);
              if (ser[id] !== e) begin
                sym_ok = 1'b0;
                badv = ser[id];
              end
              if (act[id] !== 1'b1) act_ok = 1'b0;
              if ((k > 0 || c > 0) && dn[id] !== 1'b0) dn_ok = 1'b0;
            end
            checks++;
            if (!sym_ok) begin
              errors++;
              $display("FAIL inst%0d symbol%0d of %s: line=%b required=%b", id, k, s, badv, e);
            end
          end
          chk($sformatf("inst%0d_active_in_frame %s", id, s), {31'd0, act_ok}, 32'd1);
          chk($sformatf("inst%0d_done_quiet_in_frame %s", id, s), {31'd0, dn_ok}, 32'd1);
          @(negedge clk);
          chk($sformatf("inst%0d_done_after_frame %s", id, s), {31'd0, dn[id]}, 32'd1);
          // Line high here means no follow-on start bit, so active must have dropped.
          chk($sformatf("inst%0d_active_after_frame %s", id, s), {31'd0, act[id]}, {31'd0, ~ser[id]});
          busy[id] = 1'b0;
          skip = 1'b1;
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0, 4);
      mon(1, 4);
      mon(2, 4);
      mon(3, 4);
      mon(4, 8700);
    join
  end

  initial begin
    int n;
    checks  = 0;
    errors  = 0;
    sim_end = 1'b0;
    for (int i = 0; i < N; i++) begin
      rst_n[i]  = 1'b0;
      dv[i]     = 1'b0;
      byt[i]    = '0;
      mon_en[i] = 1'b1;
      busy[i]   = 1'b0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("inst%0d_reset_serial", i), {31'd0, ser[i]}, 32'd1);
      chk($sformatf("inst%0d_reset_active", i), {31'd0, act[i]}, 32'd0);
      chk($sformatf("inst%0d_reset_done", i),   {31'd0, dn[i]},  32'd0);
      chk($sformatf("inst%0d_reset_ready", i),  {31'd0, rdy[i]}, 32'd1);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;

    // Start, data LSB first, optional parity, stop bit(s).
    push(4, "0011011");     send(4, 9'h16);
    push(1, "01010010101"); send(1, 9'hA5);
    push(2, "01010010111"); send(2, 9'hA5);
    push(3, "01000001011"); send(3, 9'h41);
    push(0, "0101001011");  send(0, 9'hA5);
    wait_idle(0);

    push(0, "0101010101");  send(0, 9'h55);
    push(0, "0111100001");  send(0, 9'h0F);
    @(negedge clk);
    chk("b2b_ready_while_full", {31'd0, rdy[0]}, 32'd0);
    dv[0]  = 1'b1;
    byt[0] = 9'hFF;
    @(posedge clk);
    #1;
    dv[0]  = 1'b0;
    wait_idle(0);

    mon_en[0] = 1'b0;
    send(0, 9'h33);
    send(0, 9'hCC);
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst_n[0] = 1'b0;
    dv[0]    = 1'b1;
    byt[0]   = 9'h77;
    @(posedge clk);
    #1;
    chk("midrst_serial", {31'd0, ser[0]}, 32'd1);
    chk("midrst_active", {31'd0, act[0]}, 32'd0);
    chk("midrst_ready",  {31'd0, rdy[0]}, 32'd1);
    chk("midrst_done",   {31'd0, dn[0]},  32'd0);
    @(negedge clk);
    rst_n[0]  = 1'b1;
    dv[0]     = 1'b0;
    mon_en[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_dv_ignored_ready", {31'd0, rdy[0]}, 32'd1);
    repeat (100) @(posedge clk);
    #1;
    chk("midrst_no_resend_active", {31'd0, act[0]}, 32'd0);
    push(0, "0101001011");  send(0, 9'hA5);
    wait_idle(0);

    n = 0;
    @(negedge clk);
    while (n < 80000 &&
           (exp_q[1].size() + exp_q[2].size() + exp_q[3].size() + exp_q[4].size() != 0 ||
            busy[1] || busy[2] || busy[3] || busy[4])) begin
      @(negedge clk);
      n++;
    end
    chk("all_frames_drained", exp_q[4].size() + exp_q[3].size() + exp_q[2].size() + exp_q[1].size(), 32'd0);
    chk("large_idle_after_frame", {31'd0, act[4]}, 32'd0);

    repeat (5) @(negedge clk);
    sim_end = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
